// File: rtl/pipe_pkg.sv
// Shared definitions for the CPU pipeline stage registers: occupancy state
// encodings and the bundle widths that stage tops use to size their payloads.
package pipe_pkg;

    localparam int DATA_BUS_WIDTH     = 32;
    localparam int REG_ADDR_BUS_WIDTH = 5;

    typedef enum logic [1:0] {
        PIPE_EMPTY = 2'd0,
        PIPE_ONE   = 2'd1,
        PIPE_TWO   = 2'd2
    } pipe_state_e;

    // The single-entry build reuses the ONE encoding as its FULL state.
    localparam pipe_state_e PIPE_FULL = PIPE_ONE;

endpackage

// File: rtl/pipe_stage_entry.sv
// One payload slot of a pipeline stage register: load enable plus a
// synchronous clear that takes priority over the load.
module pipe_stage_entry
    import pipe_pkg::*;
#(
    parameter int WIDTH = DATA_BUS_WIDTH + 1 + REG_ADDR_BUS_WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    always_comb begin
        data_d = data_q;
        if (clr) begin
            data_d = '0;
        end else if (load) begin
            data_d = d;
        end
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign q = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, flush and a
// saturating stall counter. Define PIPE_STAGE_SKID_EN for the two-entry build.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int WIDTH     = DATA_BUS_WIDTH + 1 + REG_ADDR_BUS_WIDTH,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [CNT_WIDTH-1:0] stall_cnt
);

    pipe_state_e          state_d;
    pipe_state_e          state_q;
    logic [CNT_WIDTH-1:0] stall_cnt_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q;
    logic                 xfer_in;
    logic                 xfer_out;
    logic                 main_load;
    logic [WIDTH-1:0]     main_din;
    logic                 entry_clr;

    assign out_valid = (state_q != PIPE_EMPTY);
    assign xfer_in   = in_valid && in_ready;
    assign xfer_out  = out_valid && out_ready;
    assign entry_clr = rst || flush;

`ifdef PIPE_STAGE_SKID_EN
    logic             skid_load;
    logic             main_from_skid;
    logic [WIDTH-1:0] skid_data;

    // Ready depends only on registered occupancy, so ready chains stop here.
    assign in_ready = !rst && (state_q != PIPE_TWO);
    assign main_din = main_from_skid ? skid_data : in_data;

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        skid_load      = 1'b0;
        main_from_skid = 1'b0;
        case (state_q)
            PIPE_EMPTY: begin
                if (xfer_in) begin
                    state_d   = PIPE_ONE;
                    main_load = 1'b1;
                end
            end
            PIPE_ONE: begin
                if (xfer_in && !xfer_out) begin
                    state_d   = PIPE_TWO;
                    skid_load = 1'b1;
                end else if (xfer_out && !xfer_in) begin
                    state_d = PIPE_EMPTY;
                end else if (xfer_in && xfer_out) begin
                    main_load = 1'b1;
                end
            end
            PIPE_TWO: begin
                if (xfer_out) begin
                    state_d        = PIPE_ONE;
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: state_d = PIPE_EMPTY;
        endcase
        if (flush) begin
            state_d = PIPE_EMPTY;
        end
    end

    pipe_stage_entry #(.WIDTH(WIDTH)) u_skid_entry (
        .clk  (clk),
        .clr  (entry_clr),
        .load (skid_load),
        .d    (in_data),
        .q    (skid_data)
    );
`else
    // A full stage can still accept when the held payload leaves this cycle.
    assign in_ready = !rst && (!out_valid || out_ready);
    assign main_din = in_data;

    always_comb begin
        state_d   = state_q;
        main_load = 1'b0;
        case (state_q)
            PIPE_EMPTY: begin
                if (xfer_in) begin
                    state_d   = PIPE_FULL;
                    main_load = 1'b1;
                end
            end
            PIPE_FULL: begin
                if (xfer_in) begin
                    main_load = 1'b1;
                end else if (xfer_out) begin
                    state_d = PIPE_EMPTY;
                end
            end
            default: state_d = PIPE_EMPTY;
        endcase
        if (flush) begin
            state_d = PIPE_EMPTY;
        end
    end
`endif

    pipe_stage_entry #(.WIDTH(WIDTH)) u_main_entry (
        .clk  (clk),
        .clr  (entry_clr),
        .load (main_load),
        .d    (main_din),
        .q    (out_data)
    );

    // Flush leaves the counter untouched; only reset clears it.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!flush && out_valid && !out_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= PIPE_EMPTY;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: a queue-based occupancy model predicts
// handshake outputs, and a monitor checks every delivered payload in order.
module tb_pipe_stage_reg;

    localparam int W = 38;
`ifdef PIPE_STAGE_SKID_EN
    localparam int CAPACITY = 2;
`else
    localparam int CAPACITY = 1;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [15:0]   stall_cnt;
    logic          sat_in_ready;
    logic          sat_out_valid;
    logic [W-1:0]  sat_out_data;
    logic [3:0]    sat_stall_cnt;

    logic [W-1:0]  model_q[$];
    logic [W-1:0]  exp_q[$];
    logic [W-1:0]  pending_q[$];
    int            stall_model;
    bit            zero_expected;
    int            n_compared;
    int            n_mismatched;

    always #5 clk = ~clk;

    pipe_stage_reg #(.WIDTH(W), .CNT_WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .stall_cnt (stall_cnt)
    );

    pipe_stage_reg #(.WIDTH(W), .CNT_WIDTH(4)) sat_dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (sat_in_ready),
        .in_data   (in_data),
        .out_valid (sat_out_valid),
        .out_ready (out_ready),
        .out_data  (sat_out_data),
        .stall_cnt (sat_stall_cnt)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        n_compared++;
        if (act !== req) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [W-1:0] randData();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[W-1:0];
    endfunction

    // Drives one cycle, checks the outputs visible in it, then advances the model.
    task automatic applyStimulus(input bit r, input bit f, input bit iv,
                                 input logic [W-1:0] d, input bit ordy, output bit acc);
        int  occ;
        bit  exp_ready;
        @(negedge clk);
        rst       = r;
        flush     = f;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        #1;
        occ       = model_q.size();
        exp_ready = !r && (occ < CAPACITY || (CAPACITY == 1 && ordy));
        checkOutput("in_ready", 64'(in_ready), 64'(exp_ready));
        checkOutput("out_valid", 64'(out_valid), 64'(occ > 0));
        if (occ > 0) begin
            checkOutput("out_data_head", 64'(out_data), 64'(model_q[0]));
        end else if (zero_expected) begin
            checkOutput("out_data_zero", 64'(out_data), 64'd0);
        end
        checkOutput("stall_cnt", 64'(stall_cnt), 64'((stall_model > 65535) ? 65535 : stall_model));
        checkOutput("stall_cnt_sat4", 64'(sat_stall_cnt), 64'((stall_model > 15) ? 15 : stall_model));
        acc = 1'b0;
        if (r) begin
            model_q.delete();
            exp_q.delete();
            stall_model   = 0;
            zero_expected = 1'b1;
        end else if (f) begin
            model_q.delete();
            exp_q.delete();
            zero_expected = 1'b1;
        end else begin
            if (occ > 0 && !ordy) stall_model++;
            if (occ > 0 && ordy) void'(model_q.pop_front());
            if (iv && exp_ready) begin
                acc = 1'b1;
                model_q.push_back(d);
                exp_q.push_back(d);
                zero_expected = 1'b0;
            end
        end
    endtask

    task automatic idleCycles(input int n, input bit ordy);
        bit acc;
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, '0, ordy, acc);
    endtask

    // Offers everything in pending_q in order, holding each until accepted.
    task automatic sendPending(input int stall_cycles, input int budget);
        bit acc;
        for (int i = 0; i < budget && pending_q.size() > 0; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, pending_q[0], i >= stall_cycles, acc);
            if (acc) void'(pending_q.pop_front());
        end
        if (pending_q.size() != 0) begin
            checkOutput("pending_timeout", 64'(pending_q.size()), 64'd0);
            pending_q.delete();
        end
    endtask

    // Monitor: every downstream transfer must match the oldest accepted payload.
    initial begin
        logic [W-1:0] req;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && !flush && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_compared++;
                    n_mismatched++;
                    $display("[TB] FAIL scoreboard: unexpected payload 0x%0h, expected none", out_data);
                end else begin
                    req = exp_q.pop_front();
                    checkOutput("scoreboard", 64'(out_data), 64'(req));
                end
            end
        end
    end

    initial begin
        bit acc;
        bit f;
        bit ordy;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        stall_model = 0; zero_expected = 1'b1; n_compared = 0; n_mismatched = 0;

        $display("[TB] reset with in_valid held high");
        applyStimulus(1'b1, 1'b0, 1'b1, W'(8'h55), 1'b1, acc);
        applyStimulus(1'b1, 1'b0, 1'b1, W'(8'h55), 1'b1, acc);
        idleCycles(1, 1'b1);

        $display("[TB] streaming 0x01..0x08");
        for (int i = 1; i <= 8; i++) applyStimulus(1'b0, 1'b0, 1'b1, W'(i), 1'b1, acc);
        idleCycles(2, 1'b1);

        $display("[TB] backpressure 0xA, 0xB, 0xC");
        pending_q = '{W'(8'h0A), W'(8'h0B), W'(8'h0C)};
        sendPending(5, 30);
        idleCycles(3, 1'b1);

        $display("[TB] flush with 0xFF offered");
        applyStimulus(1'b0, 1'b0, 1'b1, W'(8'h21), 1'b0, acc);
        applyStimulus(1'b0, 1'b0, 1'b1, W'(8'h22), 1'b0, acc);
        applyStimulus(1'b0, 1'b1, 1'b1, W'(8'hFF), 1'b1, acc);
        idleCycles(3, 1'b1);

        $display("[TB] stall counter saturation");
        applyStimulus(1'b0, 1'b0, 1'b1, W'(8'h33), 1'b0, acc);
        idleCycles(20, 1'b0);
        idleCycles(2, 1'b1);

        $display("[TB] simultaneous transfer in and out");
        applyStimulus(1'b0, 1'b0, 1'b1, W'(8'h44), 1'b1, acc);
        applyStimulus(1'b0, 1'b0, 1'b1, W'(8'h45), 1'b1, acc);
        applyStimulus(1'b0, 1'b0, 1'b1, W'(8'h46), 1'b1, acc);
        idleCycles(2, 1'b1);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            f    = ($urandom_range(31) == 0);
            ordy = f ? 1'b1 : ($urandom_range(2) != 0);
            applyStimulus(1'b0, f, $urandom_range(3) != 0, randData(), ordy, acc);
        end

        idleCycles(4, 1'b1);
        checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
